// File: rtl/probe_pkg.sv
// probe_pkg: shared types for the signal probe
// and its consumer-side bench
package probe_pkg;

  typedef enum logic [1:0] {
    PM_STROBE   = 2'd0,
    PM_PERIODIC = 2'd1,
    PM_CHANGE   = 2'd2,
    PM_OFF      = 2'd3
  } probe_mode_e;

  localparam int DROP_W = 16;

endpackage

// File: rtl/probe_fifo.sv
// probe_fifo: synchronous show-ahead FIFO with a
// registered head word, flush and occupancy count
module probe_fifo #(
  parameter int W     = 96,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  output logic [W-1:0]               rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] rd_nxt;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  rdata_q, rdata_d;
  logic          wr, rd;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign rdata = rdata_q;
  assign rd    = pop & ~empty;
  assign wr    = push & (~full | rd);
  assign rd_nxt = rd_ptr_q + AW'(1);

  // Pointer, count and head-word next state; flush wins
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      rdata_d  = '0;
    end else begin
      if (wr) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd) rd_ptr_d = rd_nxt;
      if (wr && !rd) cnt_d = cnt_q + CW'(1);
      else if (rd && !wr) cnt_d = cnt_q - CW'(1);
      if (rd) begin
        if (cnt_q == CW'(1)) rdata_d = wr ? wdata : '0;
        else rdata_d = mem_q[rd_nxt];
      end else if (wr && empty) begin
        rdata_d = wdata;
      end
    end
  end

  // Control and head registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (wr && !flush) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/probe_capture_fifo.sv
// probe_capture_fifo: event-triggered channel probe
// timestamps samples and queues them for a consumer
module probe_capture_fifo
  import probe_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 16,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 32,
  parameter int PER_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       clr,
  input  logic [1:0]                 cfg_mode,
  input  logic [PER_W-1:0]           cfg_period,
  input  logic                       ch_strobe,
  input  logic [NUM_CH*CH_W-1:0]     ch_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [TS_W-1:0]            out_ts,
  output logic [NUM_CH*CH_W-1:0]     out_data,
  output logic [$clog2(DEPTH+1)-1:0] fill_level,
  output logic [DROP_W-1:0]          drop_cnt,
  output logic                       overflow
);

  localparam int DW = NUM_CH*CH_W;
  localparam int EW = TS_W + DW;

  probe_mode_e       mode;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic [PER_W-1:0]  per_cnt_q, per_cnt_d;
  logic [DW-1:0]     last_q, last_d;
  logic              primed_q, primed_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              ovf_q, ovf_d;
  logic              ev, pop, push, drop;
  logic              full, empty;
  logic [EW-1:0]     rd_data;

  assign mode = probe_mode_e'(cfg_mode);

  // Capture event for the selected mode
  always_comb begin
    ev = 1'b0;
    case (mode)
      PM_STROBE:   ev = ch_strobe;
      PM_PERIODIC: ev = (per_cnt_q == cfg_period);
      PM_CHANGE:   ev = !primed_q || (ch_data != last_q);
      default:     ev = 1'b0;
    endcase
    ev = ev & enable;
  end

  assign pop  = out_valid & out_ready;
  assign push = ev & ~clr & (~full | pop);
  assign drop = ev & ~clr & full & ~pop;

  // Timestamp, trigger state and drop statistics
  always_comb begin
    ts_d      = ts_q + TS_W'(1);
    per_cnt_d = '0;
    last_d    = last_q;
    primed_d  = primed_q;
    drop_d    = drop_q;
    ovf_d     = ovf_q;
    if (!clr && enable && mode == PM_PERIODIC &&
        per_cnt_q != cfg_period)
      per_cnt_d = per_cnt_q + PER_W'(1);
    if (clr || !enable) begin
      primed_d = 1'b0;
    end else if (mode == PM_CHANGE && ev) begin
      primed_d = 1'b1;
      last_d   = ch_data;
    end
    if (clr) begin
      drop_d = '0;
      ovf_d  = 1'b0;
    end else if (drop) begin
      if (drop_q != '1) drop_d = drop_q + DROP_W'(1);
      ovf_d = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q      <= '0;
      per_cnt_q <= '0;
      last_q    <= '0;
      primed_q  <= 1'b0;
      drop_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      ts_q      <= ts_d;
      per_cnt_q <= per_cnt_d;
      last_q    <= last_d;
      primed_q  <= primed_d;
      drop_q    <= drop_d;
      ovf_q     <= ovf_d;
    end
  end

  probe_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (clr),
    .push  (push),
    .wdata ({ts_q, ch_data}),
    .pop   (pop),
    .rdata (rd_data),
    .count (fill_level),
    .full  (full),
    .empty (empty)
  );

  assign out_valid = ~empty;
  assign out_ts    = rd_data[EW-1:DW];
  assign out_data  = rd_data[DW-1:0];
  assign drop_cnt  = drop_q;
  assign overflow  = ovf_q;

endmodule
